// File: rtl/alu_cmd_sequencer.sv
// Command FIFO and registered result stage around a combinational 4-bit ALU. A command pushed into an idle stage shows a result one edge later.
// in_ready drops when the FIFO is full. A stalled result holds steady while new commands keep queueing.
module alu_cmd_sequencer #(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [2:0]              in_opcode,
  input  logic [3:0]              in_a,
  input  logic [3:0]              in_b,
  output logic [3:0]              alu_a,
  output logic [3:0]              alu_b,
  output logic [2:0]              alu_opcode,
  input  logic [7:0]              alu_result,
  input  logic                    alu_carry,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [7:0]              out_result,
  output logic                    out_carry,
  output logic                    out_zero,
  output logic                    out_div0,
  output logic [2:0]              out_opcode,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);
  localparam logic [2:0] OP_DIV = 3'b011;

  typedef struct packed {
    logic [2:0] opcode;
    logic [3:0] a;
    logic [3:0] b;
  } cmd_t;

  cmd_t          mem [DEPTH];
  cmd_t          in_cmd;
  cmd_t          head;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          empty;
  logic          push;
  logic          issue;
  logic          load_ok;

  assign in_cmd   = '{opcode: in_opcode, a: in_a, b: in_b};
  assign empty    = (count == '0);
  // Count never exceeds DEPTH, so "not full" is the same as count < DEPTH.
  assign in_ready = (count != FULL);
  assign push     = in_valid & in_ready;
  assign load_ok  = ~out_valid | out_ready;
  assign issue    = ~empty & load_ok;

  // The ALU sees only the registered FIFO head, zeroed while empty.
  assign head       = empty ? '0 : mem[rd_ptr];
  assign alu_a      = head.a;
  assign alu_b      = head.b;
  assign alu_opcode = head.opcode;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_cmd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (issue) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, issue})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Data fields keep their last value when the result is consumed with nothing behind it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_carry  <= 1'b0;
      out_zero   <= 1'b0;
      out_div0   <= 1'b0;
      out_opcode <= '0;
    end else if (issue) begin
      out_valid  <= 1'b1;
      out_result <= alu_result;
      out_carry  <= alu_carry;
      out_zero   <= (alu_result == 8'h00);
      out_div0   <= (alu_opcode == OP_DIV) && (alu_b == 4'h0);
      out_opcode <= alu_opcode;
    end else if (out_valid && out_ready) begin
      out_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: a behavioural ALU drives the alu_* loop, and a queue model predicts every output.
module tb_alu_cmd_sequencer;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_opcode;
  logic [3:0] in_a;
  logic [3:0] in_b;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [2:0] alu_opcode;
  logic [7:0] alu_result;
  logic       alu_carry;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_result;
  logic       out_carry;
  logic       out_zero;
  logic       out_div0;
  logic [2:0] out_opcode;
  logic [2:0] count;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_cmd_sequencer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_a(in_a), .in_b(in_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
    .alu_result(alu_result), .alu_carry(alu_carry),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_carry(out_carry), .out_zero(out_zero),
    .out_div0(out_div0), .out_opcode(out_opcode), .count(count)
  );

  // ALU: ADD SUB MUL DIV NAND OR XOR AVG; returns {carry, result}.
  function automatic logic [8:0] alu_fn(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    logic [4:0] s;
    logic [3:0] d;
    logic [7:0] p;
    s = {1'b0, a} + {1'b0, b};
    d = a - b;
    p = {4'h0, a} * {4'h0, b};
    case (op)
      3'd0:    return {s[4], 4'h0, s[3:0]};
      3'd1:    return {(a < b), 4'h0, d};
      3'd2:    return {1'b0, p};
      3'd3:    return (b == 4'h0) ? 9'h0FF : {1'b0, 4'h0, a / b};
      3'd4:    return {1'b0, 4'h0, ~(a & b)};
      3'd5:    return {1'b0, 4'h0, a | b};
      3'd6:    return {1'b0, 4'h0, a ^ b};
      default: return {1'b0, 4'h0, s[4:1]};
    endcase
  endfunction

  always_comb {alu_carry, alu_result} = alu_fn(alu_opcode, alu_a, alu_b);

  // Reference model: queued commands plus the held result.
  logic [10:0] mq[$];
  logic       m_held;
  logic [7:0] m_res;
  logic       m_carry, m_zero, m_div0;
  logic [2:0] m_op;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_held = 0; m_res = 0; m_carry = 0; m_zero = 0; m_div0 = 0; m_op = 0;
  endtask

  // Advance the model across one rising edge using the inputs now applied.
  task automatic model_step();
    logic [10:0] c;
    logic [8:0]  r;
    logic        do_issue, do_push;
    do_issue = (mq.size() != 0) && (!m_held || out_ready);
    do_push  = in_valid && (mq.size() < DEPTH);
    if (do_issue) begin
      c = mq.pop_front();
      r = alu_fn(c[10:8], c[7:4], c[3:0]);
      m_held = 1; m_res = r[7:0]; m_carry = r[8]; m_zero = (r[7:0] == 8'h00);
      m_div0 = (c[10:8] == 3'd3) && (c[3:0] == 4'h0); m_op = c[10:8];
    end else if (m_held && out_ready) begin
      m_held = 0;
    end
    if (do_push) mq.push_back({in_opcode, in_a, in_b});
  endtask

  task automatic check_all();
    logic [10:0] h;
    h = (mq.size() != 0) ? mq[0] : 11'h0;
    chk("count", 32'(count), mq.size());
    chk("in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
    chk("alu_opcode", 32'(alu_opcode), 32'(h[10:8]));
    chk("alu_a", 32'(alu_a), 32'(h[7:4]));
    chk("alu_b", 32'(alu_b), 32'(h[3:0]));
    chk("out_valid", 32'(out_valid), 32'(m_held));
    chk("out_result", 32'(out_result), 32'(m_res));
    chk("out_carry", 32'(out_carry), 32'(m_carry));
    chk("out_zero", 32'(out_zero), 32'(m_zero));
    chk("out_div0", 32'(out_div0), 32'(m_div0));
    chk("out_opcode", 32'(out_opcode), 32'(m_op));
  endtask

  // Called at a falling edge: apply inputs, clock once, check at the next falling edge.
  task automatic cycle(input logic v, input logic [2:0] op, input logic [3:0] a,
                       input logic [3:0] b, input logic ordy);
    in_valid = v; in_opcode = op; in_a = a; in_b = b; out_ready = ordy;
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic mid_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("rst_count", 32'(count), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_alu_a", 32'(alu_a), 0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_all();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench did not finish");
  end

  initial begin
    rst_n = 1'b0; in_valid = 0; in_opcode = 0; in_a = 0; in_b = 0; out_ready = 0;
    model_reset();
    @(negedge clk);
    check_all();
    chk("init_in_ready", 32'(in_ready), 1);
    rst_n = 1'b1;

    // Single ADD 9+8
    cycle(1, 3'd0, 4'd9, 4'd8, 1);
    cycle(0, 3'd0, 4'd0, 4'd0, 1);
    chk("add_valid", 32'(out_valid), 1);
    chk("add_result", 32'(out_result), 32'h01);
    chk("add_carry", 32'(out_carry), 1);
    chk("add_zero", 32'(out_zero), 0);
    cycle(0, 3'd0, 4'd0, 4'd0, 1);

    // Streaming MUL, SUB, NAND
    cycle(1, 3'd2, 4'hF, 4'hF, 1);
    cycle(1, 3'd1, 4'd3, 4'd5, 1);
    chk("mul_result", 32'(out_result), 32'hE1);
    cycle(1, 3'd4, 4'hF, 4'hF, 1);
    chk("sub_low", 32'(out_result[3:0]), 32'hE);
    chk("sub_borrow", 32'(out_carry), 1);
    cycle(0, 3'd0, 4'd0, 4'd0, 1);
    chk("nand_valid", 32'(out_valid), 1);
    chk("nand_zero", 32'(out_zero), 1);
    cycle(0, 3'd0, 4'd0, 4'd0, 1);

    // Back-pressure fill and in-order drain
    for (int i = 0; i < 5; i++) cycle(1, 3'd0, 4'(i + 1), 4'd2, 0);
    chk("bp_count", 32'(count), 4);
    chk("bp_in_ready", 32'(in_ready), 0);
    chk("bp_held_first", 32'(out_result), 32'h03);
    cycle(1, 3'd2, 4'hF, 4'hF, 0);
    chk("bp_rejected", 32'(count), 4);
    for (int i = 0; i < 5; i++) cycle(0, 3'd0, 4'd0, 4'd0, 1);
    chk("bp_drained", 32'(out_valid), 0);

    // Divide-by-zero flag
    cycle(1, 3'd3, 4'd7, 4'd0, 1);
    cycle(1, 3'd3, 4'd7, 4'd2, 1);
    chk("div0_flag", 32'(out_div0), 1);
    chk("div0_opcode", 32'(out_opcode), 3);
    cycle(0, 3'd0, 4'd0, 4'd0, 1);
    chk("div_flag_clear", 32'(out_div0), 0);
    chk("div_result", 32'(out_result), 3);
    cycle(0, 3'd0, 4'd0, 4'd0, 1);

    // Pointer wrap at steady occupancy 3
    for (int i = 0; i < 4; i++) cycle(1, 3'(i), 4'(i + 4), 4'(i + 1), 0);
    for (int i = 0; i < 10; i++) begin
      cycle(1, 3'($urandom_range(0, 7)), 4'($urandom), 4'($urandom), 1);
      chk("wrap_count", 32'(count), 3);
    end

    // Reset mid-burst
    mid_reset();

    // Randomized traffic with a reset in the middle
    for (int i = 0; i < 400; i++) begin
      if (i == 200) mid_reset();
      cycle(($urandom_range(0, 3) != 0), 3'($urandom), 4'($urandom), 4'($urandom),
            ($urandom_range(0, 2) != 0));
    end
    for (int i = 0; i < 8; i++) cycle(0, 3'd0, 4'd0, 4'd0, 1);
    chk("final_empty", 32'(count), 0);
    chk("final_out_valid", 32'(out_valid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_cmd_sequencer.md
# alu_cmd_sequencer

Command-queue and result-capture stage wrapped around the combinational 4-bit ALU. Upstream logic pushes (opcode, A, B) commands through a valid/ready port into a small FIFO. The sequencer drives the FIFO head onto the ALU operand/opcode inputs and captures the ALU's 8-bit result, carry and derived status flags into a registered output with its own valid/ready handshake. It gives the purely combinational ALU back-pressure, buffering and a registered result boundary.

## Interface
- DEPTH, 4, command FIFO depth; power of two, ≥2
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  command present
- in_ready  out  1  FIFO can accept; equals (count < DEPTH)
- in_opcode  in  3  ALU opcode (000 ADD … 111 AVG)
- in_a  in  4  operand A
- in_b  in  4  operand B
- alu_a  out  4  FIFO-head A to ALU; 0 when FIFO empty
- alu_b  out  4  FIFO-head B to ALU; 0 when FIFO empty
- alu_opcode  out  3  FIFO-head opcode to ALU; 0 when FIFO empty
- alu_result  in  8  ALU result, combinational from alu_* in same cycle
- alu_carry  in  1  ALU carry/borrow out
- out_valid  out  1  registered result held
- out_ready  in  1  consumer accepts result
- out_result  out  8  captured result
- out_carry  out  1  captured carry
- out_zero  out  1  1 when captured result == 8'h00
- out_div0  out  1  1 when captured command was DIV (011) with B == 0
- out_opcode  out  3  opcode of captured command
- count  out  log2(DEPTH)+1  FIFO occupancy, 0..DEPTH

## Operation
- FIFO: circular buffer, write/read pointers log2(DEPTH) bits, wrap modulo DEPTH; occupancy counter separate.
- push = in_valid & in_ready. in_ready is de-asserted when count == DEPTH, even if a pop occurs in the same cycle (no full-bypass).
- Output register free condition: load_ok = !out_valid | out_ready.
- issue = (count != 0) & load_ok. On issue: out_result <= alu_result, out_carry <= alu_carry, out_zero <= (alu_result == 0), out_div0 <= (alu_opcode == 011 & alu_b == 0), out_opcode <= alu_opcode, out_valid <= 1, FIFO pops.
- If out_valid & out_ready and the FIFO is empty, out_valid <= 0. Data fields hold their last value.
- While out_valid & !out_ready, all out_* fields are stable. Commands keep accumulating until the FIFO is full.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Push into an empty FIFO is not visible at alu_* until the following cycle (no FIFO bypass).
- Commands complete strictly in order. None is dropped or duplicated.
- Reset: pointers, count, out_valid, out_result, out_carry, out_zero, out_div0 and out_opcode all go to 0. in_ready = 1 after reset. A reset mid-stream discards queued commands and any held result.

## Timing
- Latency: a command pushed at edge N, with the FIFO empty and the output free, appears with out_valid = 1 after edge N+1.
- Throughput: one result per cycle while out_ready = 1 and the FIFO is non-empty.
- alu_* outputs are combinational from the FIFO head registers only. They must not depend on in_*.
- in_ready depends only on count and is registered-derived, so there is no combinational path from out_ready.
- No combinational path from in_valid or out_ready to any output except through registers.
- DEPTH commands can be held in the FIFO plus 1 in the output register.

## Test plan
- Reset with stream active: assert rst_n = 0 mid-burst → count = 0, out_valid = 0, out_* = 0, in_ready = 1, alu_* = 0 immediately.
- Single ADD: push opcode 000, A = 9, B = 8 at edge N, out_ready = 1 → out_valid after N+1, out_result = 8'h01, out_carry = 1, out_zero = 0.
- Back-pressure fill: out_ready = 0, push 5 commands with DEPTH = 4 → first command captured in the output register, in_ready = 0 after count reaches 4. Raise out_ready → results drain in push order, one per cycle.
- Streaming: push MUL 15×15, SUB 3−5, NAND 0xF,0xF on consecutive cycles with out_ready = 1 → outputs on consecutive cycles: 8'hE1; low nibble 4'hE with ALU-reported borrow; NAND result with out_zero as the ALU produces.
- Div-by-zero flag: push DIV A = 7, B = 0 → out_div0 = 1, out_opcode = 011. Next DIV A = 7, B = 2 → out_div0 = 0, out_result = 3.
- Pointer wrap: with count = 3 and DEPTH = 4, push and pop every cycle for 10 cycles → count stays 3, ordering preserved across the pointer wrap.
